// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and transfer helpers for the memory slave.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_LAST = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } ahb_state_e;

    localparam logic [2:0] ST_IDLE = S_IDLE;
    localparam logic [2:0] ST_WAIT = S_WAIT;
    localparam logic [2:0] ST_LAST = S_LAST;
    localparam logic [2:0] ST_ERR1 = S_ERR1;
    localparam logic [2:0] ST_ERR2 = S_ERR2;

    // Oversized or misaligned transfers are answered with ERROR.
    function automatic logic xfer_illegal(input logic [2:0] size, input logic [1:0] a);
        case (size)
            HSIZE_BYTE: xfer_illegal = 1'b0;
            HSIZE_HALF: xfer_illegal = a[0];
            HSIZE_WORD: xfer_illegal = (a != 2'b00);
            default:    xfer_illegal = 1'b1;
        endcase
    endfunction

    // Little-endian byte lanes touched by a legal transfer.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
        case (size)
            HSIZE_BYTE: lane_mask = 4'b0001 << a;
            HSIZE_HALF: lane_mask = a[1] ? 4'b1100 : 4'b0011;
            default:    lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite slave-side bus bundle: address/data phase inputs and response outputs.
interface ahb_slave_mem_if #(
    parameter int addr_width = 12
);
    logic                  HSEL;
    logic [addr_width-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [31:0]           HWDATA;
    logic                  HREADY;
    logic [31:0]           HRDATA;
    logic                  HREADYOUT;
    logic                  HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_mem_array.sv
// Word-organised RAM, one byte array per lane; synchronous write, combinational read.
module ahb_mem_array #(
    parameter int word_aw = 10
) (
    input  logic               clk,
    input  logic [3:0]         be,
    input  logic [word_aw-1:0] waddr,
    input  logic [31:0]        wdata,
    input  logic [word_aw-1:0] raddr,
    output logic [31:0]        rdata
);
    localparam int DEPTH = 1 << word_aw;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];

        always_ff @(posedge clk) begin
            if (be[g]) lane_mem[waddr] <= wdata[8*g +: 8];
        end

        assign rdata[8*g +: 8] = lane_mem[raddr];
    end
endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave with a fixed number of wait states, two-cycle ERROR
// responses and write-to-read forwarding on back-to-back transfers.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int addr_width  = 12,
    parameter int data_width  = 32,
    parameter int wait_states = 1
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    ahb_slave_mem_if.slave    bus
);
    localparam int         WORD_AW   = addr_width - 2;
    localparam int         NBYTES    = data_width / 8;
    localparam bit         ZERO_WAIT = (wait_states == 0);
    localparam logic [3:0] WS_LOAD   = (wait_states > 0) ? 4'(wait_states - 1) : 4'd0;

    logic [2:0]            state;
    logic [3:0]            cnt;
    logic                  dp_valid;
    logic                  dp_write;
    logic [addr_width-1:0] dp_addr;
    logic [2:0]            dp_size;
    logic [31:0]           rdata_q;

    logic                  ready;
    logic                  active;
    logic                  accept;
    logic                  illegal;
    logic                  wr_fire;
    logic                  fwd;
    logic [3:0]            wr_be;
    logic [31:0]           ram_rdata;
    logic [31:0]           rd_word;

    assign ready   = !(state == ST_WAIT || state == ST_ERR1);
    assign active  = (bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ);
    // Only a state that is driving HREADYOUT high can open a new address phase.
    assign accept  = bus.HSEL & bus.HREADY & active & ready;
    assign illegal = xfer_illegal(bus.HSIZE, bus.HADDR[1:0]);

    // A write commits on its last data-phase edge; reset on that edge drops it.
    assign wr_fire = dp_valid & dp_write & ready & HRESETn;
    assign wr_be   = wr_fire ? lane_mask(dp_size, dp_addr[1:0]) : 4'b0000;
    assign fwd     = wr_fire && (dp_addr[addr_width-1:2] == bus.HADDR[addr_width-1:2]);

    for (genvar i = 0; i < NBYTES; i++) begin : g_fwd
        assign rd_word[8*i +: 8] = (fwd && wr_be[i]) ? bus.HWDATA[8*i +: 8]
                                                     : ram_rdata[8*i +: 8];
    end

    ahb_mem_array #(
        .word_aw (WORD_AW)
    ) u_mem (
        .clk   (HCLK),
        .be    (wr_be),
        .waddr (dp_addr[addr_width-1:2]),
        .wdata (bus.HWDATA),
        .raddr (bus.HADDR[addr_width-1:2]),
        .rdata (ram_rdata)
    );

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
            dp_size  <= HSIZE_BYTE;
            rdata_q  <= 32'd0;
        end else begin
            case (state)
                ST_IDLE, ST_LAST, ST_ERR2: begin
                    if (accept) begin
                        if (illegal) begin
                            state <= ST_ERR1;
                        end else if (ZERO_WAIT) begin
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= WS_LOAD;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) state <= ST_LAST;
                    else             cnt   <= cnt - 4'd1;
                end
                ST_ERR1: state <= ST_ERR2;
                default: state <= ST_IDLE;
            endcase

            // Data-phase bookkeeping advances only on edges that end a data phase.
            if (ready) begin
                dp_valid <= accept & ~illegal;
                if (accept) begin
                    dp_write <= bus.HWRITE;
                    dp_addr  <= bus.HADDR;
                    dp_size  <= bus.HSIZE;
                end
                if (accept && !illegal && !bus.HWRITE) rdata_q <= rd_word;
            end
        end
    end

    assign bus.HRDATA    = rdata_q;
    assign bus.HREADYOUT = ready;
    assign bus.HRESP     = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: one zero-wait and one three-wait instance, table vectors,
// hand-written pipelined/reset sequences and random transfers against a byte-level model.
module tb_ahb_slave_mem;

    logic        HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    logic        rstn   [2];
    logic        hsel   [2];
    logic [11:0] haddr  [2];
    logic [1:0]  htrans [2];
    logic        hwrite [2];
    logic [2:0]  hsize  [2];
    logic [31:0] hwdata [2];
    logic        block  [2];
    logic [31:0] rd_w   [2];
    logic        rdy_w  [2];
    logic        rsp_w  [2];

    ahb_slave_mem_if #(.addr_width(12)) b0 ();
    ahb_slave_mem_if #(.addr_width(12)) b1 ();

    assign b0.HSEL   = hsel[0];   assign b1.HSEL   = hsel[1];
    assign b0.HADDR  = haddr[0];  assign b1.HADDR  = haddr[1];
    assign b0.HTRANS = htrans[0]; assign b1.HTRANS = htrans[1];
    assign b0.HWRITE = hwrite[0]; assign b1.HWRITE = hwrite[1];
    assign b0.HSIZE  = hsize[0];  assign b1.HSIZE  = hsize[1];
    assign b0.HWDATA = hwdata[0]; assign b1.HWDATA = hwdata[1];
    assign b0.HREADY = b0.HREADYOUT & ~block[0];
    assign b1.HREADY = b1.HREADYOUT & ~block[1];
    assign rd_w[0]  = b0.HRDATA;    assign rd_w[1]  = b1.HRDATA;
    assign rdy_w[0] = b0.HREADYOUT; assign rdy_w[1] = b1.HREADYOUT;
    assign rsp_w[0] = b0.HRESP;     assign rsp_w[1] = b1.HRESP;

    ahb_slave_mem #(.addr_width(12), .data_width(32), .wait_states(0)) dut0 (
        .HCLK(HCLK), .HRESETn(rstn[0]), .bus(b0.slave));
    ahb_slave_mem #(.addr_width(12), .data_width(32), .wait_states(3)) dut3 (
        .HCLK(HCLK), .HRESETn(rstn[1]), .bus(b1.slave));

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model   [2][1024];
    logic [31:0] last_rd [2];

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        bit          err;
        logic [31:0] rdata;
    } vec_t;
    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // One non-pipelined transfer; returns what the bus showed in its data phase.
    task automatic xfer(input int d, input bit wr, input logic [11:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd, output bit rf,
                        output bit rl, output int lows);
        hsel[d] = 1'b1; htrans[d] = 2'b10; hwrite[d] = wr; haddr[d] = a; hsize[d] = sz;
        tick();
        hsel[d] = 1'b0; htrans[d] = 2'b00; hwdata[d] = wd; haddr[d] = 12'($urandom);
        lows = 0;
        rf = rsp_w[d];
        while (!rdy_w[d] && lows < 64) begin
            lows++;
            tick();
        end
        rd = rd_w[d];
        rl = rsp_w[d];
        tick();
        hwdata[d] = $urandom;
    endtask

    // Transfer checked against the byte-level memory model.
    task automatic mxfer(input int d, input bit wr, input logic [11:0] a, input logic [2:0] sz,
                         input logic [31:0] wd, input string tag, output logic [31:0] got);
        bit          ill, rf, rl;
        int          ws, lows, nb, idx;
        logic [31:0] w, rd;
        ill = (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00);
        ws  = (d == 0) ? 0 : 3;
        w   = model[d][a[11:2]];
        xfer(d, wr, a, sz, wd, rd, rf, rl, lows);
        if (!ill && !wr) last_rd[d] = w;
        chk({tag, ":first_resp"}, 32'(rf), 32'(ill));
        chk({tag, ":low_cycles"}, 32'(lows), ill ? 32'd1 : 32'(ws));
        chk({tag, ":last_resp"}, 32'(rl), 32'(ill));
        chk({tag, ":rdata"}, rd, last_rd[d]);
        if (!ill && wr) begin
            nb = 1 << sz;
            for (int k = 0; k < nb; k++) begin
                idx = int'(a[1:0]) + k;
                w[8*idx +: 8] = wd[8*idx +: 8];
            end
            model[d][a[11:2]] = w;
        end
        got = rd;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [31:0] got, rd;
        bit          rf, rl;
        int          lows, r;
        logic [11:0] base;
        logic [2:0]  sz;

        for (int d = 0; d < 2; d++) begin
            rstn[d] = 1'b0; hsel[d] = 1'b0; haddr[d] = '0; htrans[d] = 2'b00;
            hwrite[d] = 1'b0; hsize[d] = 3'd2; hwdata[d] = '0; block[d] = 1'b0;
        end

        // Reset
        repeat (2) @(posedge HCLK);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset%0d:hrdata", d), rd_w[d], 32'd0);
            chk($sformatf("reset%0d:hreadyout", d), 32'(rdy_w[d]), 32'd1);
            chk($sformatf("reset%0d:hresp", d), 32'(rsp_w[d]), 32'd0);
            rstn[d] = 1'b1;
            last_rd[d] = 32'd0;
        end
        tick();

        // Back-to-back write/read with forwarding, zero wait states
        hsel[0] = 1'b1; htrans[0] = 2'b10; hwrite[0] = 1'b1; haddr[0] = 12'h010; hsize[0] = 3'd2;
        tick();
        hwrite[0] = 1'b0; hwdata[0] = 32'hDEADBEEF;
        tick();
        chk("fwd_word:hrdata", rd_w[0], 32'hDEADBEEF);
        chk("fwd_word:hreadyout", 32'(rdy_w[0]), 32'd1);
        hwrite[0] = 1'b1; haddr[0] = 12'h012; hsize[0] = 3'd0; hwdata[0] = $urandom;
        tick();
        hwrite[0] = 1'b0; haddr[0] = 12'h010; hsize[0] = 3'd2; hwdata[0] = 32'hAA55AAAA;
        tick();
        chk("fwd_byte:hrdata", rd_w[0], 32'hDE55BEEF);
        hsel[0] = 1'b0; htrans[0] = 2'b00;
        tick();
        last_rd[0] = 32'hDE55BEEF;

        // Table vectors, zero wait states; rdata is HRDATA in the final data cycle
        tbl[0]  = '{1'b1, 12'h004, 3'd2, 32'h01234567, 1'b0, 32'hDE55BEEF};
        tbl[1]  = '{1'b0, 12'h004, 3'd2, 32'h0,        1'b0, 32'h01234567};
        tbl[2]  = '{1'b1, 12'h006, 3'd1, 32'hBEEF1111, 1'b0, 32'h01234567};
        tbl[3]  = '{1'b0, 12'h004, 3'd2, 32'h0,        1'b0, 32'hBEEF4567};
        tbl[4]  = '{1'b1, 12'h005, 3'd1, 32'hFFFFFFFF, 1'b1, 32'hBEEF4567};
        tbl[5]  = '{1'b0, 12'h004, 3'd2, 32'h0,        1'b0, 32'hBEEF4567};
        tbl[6]  = '{1'b1, 12'h008, 3'd3, 32'hFFFFFFFF, 1'b1, 32'hBEEF4567};
        tbl[7]  = '{1'b1, 12'h007, 3'd0, 32'h11223344, 1'b0, 32'hBEEF4567};
        tbl[8]  = '{1'b0, 12'h004, 3'd2, 32'h0,        1'b0, 32'h11EF4567};
        tbl[9]  = '{1'b0, 12'h012, 3'd1, 32'h0,        1'b0, 32'hDE55BEEF};
        tbl[10] = '{1'b0, 12'h010, 3'd4, 32'h0,        1'b1, 32'hDE55BEEF};
        tbl[11] = '{1'b0, 12'h011, 3'd0, 32'h0,        1'b0, 32'hDE55BEEF};
        tbl[12] = '{1'b0, 12'h002, 3'd2, 32'h0,        1'b1, 32'hDE55BEEF};
        tbl[13] = '{1'b1, 12'h008, 3'd2, 32'hCAFEF00D, 1'b0, 32'hDE55BEEF};
        tbl[14] = '{1'b0, 12'h00A, 3'd1, 32'h0,        1'b0, 32'hCAFEF00D};
        for (int i = 0; i < 15; i++) begin
            xfer(0, tbl[i].wr, tbl[i].addr, tbl[i].size, tbl[i].wdata, rd, rf, rl, lows);
            chk($sformatf("vec%0d:first_resp", i), 32'(rf), 32'(tbl[i].err));
            chk($sformatf("vec%0d:last_resp", i), 32'(rl), 32'(tbl[i].err));
            chk($sformatf("vec%0d:low_cycles", i), 32'(lows), tbl[i].err ? 32'd1 : 32'd0);
            chk($sformatf("vec%0d:rdata", i), rd, tbl[i].rdata);
        end
        last_rd[0] = 32'hCAFEF00D;

        // Known contents for the random windows
        for (int d = 0; d < 2; d++) begin
            base = (d == 0) ? 12'h080 : 12'h000;
            for (int i = 0; i < 16; i++)
                mxfer(d, 1'b1, base + 12'(4 * i), 3'd2, $urandom, $sformatf("init%0d", d), got);
        end

        // HREADY low from elsewhere blocks acceptance
        block[0] = 1'b1;
        hsel[0] = 1'b1; htrans[0] = 2'b10; hwrite[0] = 1'b1; haddr[0] = 12'h080; hsize[0] = 3'd2;
        tick();
        chk("blocked:hreadyout", 32'(rdy_w[0]), 32'd1);
        hsel[0] = 1'b0; htrans[0] = 2'b00; block[0] = 1'b0; hwdata[0] = 32'hFFFFFFFF;
        tick();
        mxfer(0, 1'b0, 12'h080, 3'd2, 32'h0, "blocked_read", got);

        // Three wait states: low for exactly 3 cycles, then valid data
        mxfer(1, 1'b0, 12'h004, 3'd2, 32'h0, "ws3_read", got);

        // Misaligned word write: ERR1 then ERR2, memory untouched
        mxfer(1, 1'b1, 12'h013, 3'd2, 32'h77777777, "err_write", got);
        mxfer(1, 1'b0, 12'h010, 3'd2, 32'h0, "err_after_read", got);

        // Reset in the second WAIT cycle of a write
        mxfer(1, 1'b1, 12'h020, 3'd2, 32'h0BADF00D, "pre_rst_write", got);
        mxfer(1, 1'b0, 12'h004, 3'd2, 32'h0, "pre_rst_read", got);
        hsel[1] = 1'b1; htrans[1] = 2'b10; hwrite[1] = 1'b1; haddr[1] = 12'h020; hsize[1] = 3'd2;
        tick();
        chk("rst_mid:wait1_ready", 32'(rdy_w[1]), 32'd0);
        hsel[1] = 1'b0; htrans[1] = 2'b00; hwdata[1] = 32'h12345678;
        tick();
        chk("rst_mid:wait2_ready", 32'(rdy_w[1]), 32'd0);
        rstn[1] = 1'b0;
        tick();
        chk("rst_mid:hrdata", rd_w[1], 32'd0);
        chk("rst_mid:hreadyout", 32'(rdy_w[1]), 32'd1);
        chk("rst_mid:hresp", 32'(rsp_w[1]), 32'd0);
        rstn[1] = 1'b1;
        last_rd[1] = 32'd0;
        tick();
        mxfer(1, 1'b0, 12'h020, 3'd2, 32'h0, "rst_read", got);
        checks++;
        if (got === 32'h12345678) begin
            failures++;
            $display("FAIL rst_read:discarded actual=%h required=not_12345678", got);
        end

        // Random traffic against the model
        for (int d = 0; d < 2; d++) begin
            base = (d == 0) ? 12'h080 : 12'h000;
            for (int i = 0; i < 120; i++) begin
                r  = $urandom_range(0, 9);
                sz = (r < 8) ? 3'(r % 3) : 3'($urandom_range(3, 7));
                mxfer(d, 1'($urandom), base + 12'($urandom_range(0, 63)), sz, $urandom,
                      $sformatf("rand%0d_%0d", d, i), got);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_slave_mem.md
# ahb_slave_mem

AHB-Lite memory slave with configurable wait states, sitting directly downstream of the address decoder. It consumes one decoder HSEL output and serves single and pipelined read/write transfers to an internal word-organised RAM. Its HRDATA, HREADYOUT and HRESP go to the bus response mux. It returns a two-cycle ERROR response for illegal sizes and misaligned transfers.

## Interface
- addr_width, 12, byte-address bits decoded by this slave (RAM depth 2^(addr_width-2) words)
- data_width, 32, bus data width (fixed at 32; other values unsupported)
- wait_states, 1, extra data-phase cycles per transfer (0..15)
- HCLK  input  1  bus clock; all state changes on rising edge
- HRESETn  input  1  reset; synchronous and active-low
- HSEL  input  1  slave select from decoder
- HADDR  input  addr_width  transfer byte address
- HTRANS  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HWRITE  input  1  1 = write
- HSIZE  input  3  000 byte, 001 halfword, 010 word; others illegal
- HWDATA  input  32  write data (data phase)
- HREADY  input  1  bus-level ready (from response mux)
- HRDATA  output  32  read data
- HREADYOUT  output  1  this slave's ready
- HRESP  output  1  0 = OKAY, 1 = ERROR

## Operation
- Accept: an address phase is accepted on a rising edge where HSEL & HREADY & HTRANS[1]. At acceptance, register HADDR, HWRITE and HSIZE.
- IDLE/BUSY with HSEL, or any cycle without HSEL: no transfer. Output is HREADYOUT=1, HRESP=0.
- Illegal transfer: HSIZE>2, halfword with HADDR[0]=1, or word with HADDR[1:0]!=0.
  - Go to ERR1, then ERR2. No RAM access.
- States:
  - IDLE: HREADYOUT=1.
    - Legal accept with wait_states>0: go to WAIT.
    - Legal accept with wait_states=0: stay in IDLE; the data phase is the next cycle.
    - Illegal accept: go to ERR1.
  - WAIT: HREADYOUT=0. A down-counter is loaded with wait_states-1 at acceptance.
    - Leave for LAST when the counter reaches 0.
  - LAST: HREADYOUT=1 (final data cycle).
    - New accept: handle as in IDLE.
    - No accept: go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1. Always go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Accepts a new address phase like IDLE.
- Write: HWDATA is sampled on the final data-phase edge (HREADYOUT=1). Byte lanes are little-endian, selected by the registered HADDR[1:0] and HSIZE.
  - Byte: 1 lane.
  - Halfword: lanes {1,0} or {3,2}.
  - Word: all 4 lanes.
- Read: the RAM word at HADDR[addr_width-1:2] is registered into HRDATA at acceptance. HRDATA holds until the next read is accepted. All 4 lanes are driven regardless of size.
- Read-after-write forwarding: a read may be accepted on the same edge as the final data phase of a write to the same word. In that case HRDATA takes the written byte lanes from HWDATA and the remaining lanes from RAM.
- Reset: state IDLE, counter 0, HRDATA=0, HREADYOUT=1, HRESP=0. RAM contents are not reset.
- Reset mid-transfer: the transfer is abandoned and a pending write is discarded. The next cycle sees the reset values.

## Timing
- wait_states=0: zero-wait. Read data is valid in the cycle after the address phase, and back-to-back transfers run one per cycle.
- wait_states=N: data phase lasts N+1 cycles, with HREADYOUT low for exactly N cycles.
- Error: always 2 data cycles, independent of wait_states.
- HRDATA is stable from the first data cycle through LAST.
- HREADY=0 from another slave blocks acceptance even when HSEL=1 and HTRANS=NONSEQ.

## Structure
- Package ahb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ constants
  - HSIZE_BYTE/HALF/WORD constants
  - HRESP_OKAY/ERROR constants
  - the state enum
- Sub-module ahb_mem_array: word-wide RAM with 4 byte-enables, synchronous write and combinational read. Forwarding stays in the top level.

## Test plan
- Reset: hold HRESETn=0 for 2 cycles → HRDATA=0, HREADYOUT=1, HRESP=0.
- Word write then read, wait_states=0:
  - Write 0xDEADBEEF at 0x010, then NONSEQ read of 0x010 back-to-back.
  - Required: HRDATA=0xDEADBEEF in the read data phase (forwarding path).
- Byte write:
  - After the word above, write byte 0x55 to 0x012, then read 0x010.
  - Required: HRDATA=0xDE55BEEF.
- Wait states, wait_states=3:
  - Read a word.
  - Required: HREADYOUT low for exactly 3 cycles, then high for 1 cycle with valid data.
- Error:
  - Word write at 0x013.
  - Required: cycle 1 HRESP=1/HREADYOUT=0, cycle 2 HRESP=1/HREADYOUT=1; reading 0x010 afterwards is unchanged.
- Reset mid-transfer, wait_states=3:
  - Assert HRESETn=0 in the second WAIT cycle of a write of 0x12345678 to 0x020.
  - Required: reset values next cycle; a later read of 0x020 does not return 0x12345678.
